// File: rtl/vga_timing_if.sv
// Renderer/VGA-pin bundle for the raster timing generator.
// master = timing generator, slave = renderer / pin consumer.
interface vga_timing_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10,
    parameter int unsigned CW = 4
);
    logic [CW-1:0] pix_r;
    logic [CW-1:0] pix_g;
    logic [CW-1:0] pix_b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          de;
    logic          pix_ce;
    logic          frame_start;
    logic [CW-1:0] VGA_R;
    logic [CW-1:0] VGA_G;
    logic [CW-1:0] VGA_B;
    logic          HS;
    logic          VS;

    modport master (
        input  pix_r, pix_g, pix_b,
        output x, y, de, pix_ce, frame_start,
        output VGA_R, VGA_G, VGA_B, HS, VS
    );

    modport slave (
        output pix_r, pix_g, pix_b,
        input  x, y, de, pix_ce, frame_start,
        input  VGA_R, VGA_G, VGA_B, HS, VS
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, h/v counters,
// and a registered RGB/HS/VS output stage aligned one pixel behind x,y.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    vga_timing_if.master  bus
);
    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW         = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned YW         = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

    logic [DW-1:0] div_cnt;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] r_q, g_q, b_q;
    logic          hs_q, vs_q;

    logic run_ce_c, x_last_c, y_last_c, active_c, hs_on_c, vs_on_c;

    // Decode of the current raster position; widened compares avoid truncating the limits.
    always_comb begin
        run_ce_c = en && (div_cnt == DW'(CLK_DIV - 1));
        x_last_c = (x_q == XW'(H_TOTAL - 1));
        y_last_c = (y_q == YW'(V_TOTAL - 1));
        active_c = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
        hs_on_c  = (32'(x_q) >= H_SYNC_BEG) && (32'(x_q) < H_SYNC_END);
        vs_on_c  = (32'(y_q) >= V_SYNC_BEG) && (32'(y_q) < V_SYNC_END);
    end

    // Pixel divider and raster counters; en low parks everything at the frame origin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (!en) begin
            div_cnt <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            div_cnt <= (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
            if (run_ce_c) begin
                x_q <= x_last_c ? '0 : x_q + 1'b1;
                if (x_last_c) begin
                    y_q <= y_last_c ? '0 : y_q + 1'b1;
                end
            end
        end
    end

    // Output stage samples the pixel at x,y, so RGB, HS and VS share one pixel of latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
        end else if (!en) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
        end else if (run_ce_c) begin
            r_q  <= active_c ? bus.pix_r : '0;
            g_q  <= active_c ? bus.pix_g : '0;
            b_q  <= active_c ? bus.pix_b : '0;
            hs_q <= hs_on_c ? HS_POL : ~HS_POL;
            vs_q <= vs_on_c ? VS_POL : ~VS_POL;
        end
    end

    // Strobes are masked by rstn so they read idle for the whole reset window.
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.de          = rstn && active_c;
    assign bus.pix_ce      = rstn && run_ce_c;
    assign bus.frame_start = rstn && run_ce_c && (x_q == '0) && (y_q == '0);
    assign bus.VGA_R       = r_q;
    assign bus.VGA_G       = g_q;
    assign bus.VGA_B       = b_q;
    assign bus.HS          = hs_q;
    assign bus.VS          = vs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 8x6 raster: a cycle-count arithmetic model
// predicts every output; a second instance covers CLK_DIV=1 with active-high HS.
module tb_vga_timing_gen;
    localparam int unsigned HT = 8;
    localparam int unsigned VT = 6;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       de;
        logic       pix_ce;
        logic       fs;
        logic       hs;
        logic       vs;
    } sig_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a = 1'b1, en_a = 1'b1;
    logic rstn_b = 1'b1, en_b = 1'b1;

    vga_timing_if #(.XW(3), .YW(3), .CW(4)) bus_a();
    vga_timing_if #(.XW(3), .YW(3), .CW(4)) bus_b();

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .CW(4)
    ) dut_a (.clk(clk), .rstn(rstn_a), .en(en_a), .bus(bus_a));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
    ) dut_b (.clk(clk), .rstn(rstn_b), .en(en_b), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    int unsigned n_a, n_b;
    sig_t        exp_a, exp_b;
    bit          vis_a, vis_b;
    logic [11:0] cap_rgb;
    bit          rand_pix = 1'b1;
    logic [3:0]  fix_r = 4'h0;

    // n = clock edges run with en=1 since the last idle point; everything follows from it.
    function automatic void model(input int unsigned n, input int unsigned d,
                                  input bit run, input bit hpol,
                                  output sig_t s, output bit vis);
        int unsigned p, q, qx, qy;
        p        = n / d;
        s.x      = 3'(p % HT);
        s.y      = 3'((p / HT) % VT);
        s.de     = (s.x < 3'd4) && (s.y < 3'd3);
        s.pix_ce = run && ((n % d) == (d - 1));
        s.fs     = s.pix_ce && (s.x == 3'd0) && (s.y == 3'd0);
        if (p == 0) begin
            s.hs = ~hpol;
            s.vs = 1'b1;
            vis  = 1'b0;
        end else begin
            q    = p - 1;
            qx   = q % HT;
            qy   = (q / HT) % VT;
            s.hs = (qx >= 5 && qx < 7) ? hpol : ~hpol;
            s.vs = (qy == 4) ? 1'b0 : 1'b1;
            vis  = (qx < 4) && (qy < 3);
        end
    endfunction

    function automatic sig_t obs_a();
        return {bus_a.x, bus_a.y, bus_a.de, bus_a.pix_ce, bus_a.frame_start, bus_a.HS, bus_a.VS};
    endfunction

    function automatic sig_t obs_b();
        return {bus_b.x, bus_b.y, bus_b.de, bus_b.pix_ce, bus_b.frame_start, bus_b.HS, bus_b.VS};
    endfunction

    function automatic logic [11:0] exp_rgb_a();
        return vis_a ? cap_rgb : 12'h000;
    endfunction

    task automatic prep_a(input bit en_v);
        @(negedge clk);
        en_a = en_v;
        bus_a.pix_r = rand_pix ? 4'($urandom) : fix_r;
        bus_a.pix_g = 4'($urandom);
        bus_a.pix_b = 4'($urandom);
        #1;
        model(n_a, 2, en_a, 1'b0, exp_a, vis_a);
    endtask

    task automatic tick_a(input bit en_v);
        if (exp_a.pix_ce) cap_rgb = {bus_a.pix_r, bus_a.pix_g, bus_a.pix_b};
        @(posedge clk);
        n_a = (en_a && rstn_a) ? n_a + 1 : 0;
        prep_a(en_v);
    endtask

    task automatic tick_b();
        @(posedge clk);
        n_b = (en_b && rstn_b) ? n_b + 1 : 0;
        @(negedge clk);
        #1;
        model(n_b, 1, en_b, 1'b1, exp_b, vis_b);
    endtask

    task automatic test_reset();
        sig_t idle_a, idle_b;
        idle_a = {3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        idle_b = {3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus_a.pix_r = 4'hF; bus_a.pix_g = 4'hF; bus_a.pix_b = 4'hF;
        bus_b.pix_r = 4'h0; bus_b.pix_g = 4'h0; bus_b.pix_b = 4'h0;
        #2;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (obs_a() !== idle_a) begin
            errors++;
            $display("FAIL reset_a_sigs got %h want %h", obs_a(), idle_a);
        end
        checks++;
        if ({bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B} !== 12'h000) begin
            errors++;
            $display("FAIL reset_a_rgb got %h want 000", {bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B});
        end
        checks++;
        if (obs_b() !== idle_b) begin
            errors++;
            $display("FAIL reset_b_sigs got %h want %h", obs_b(), idle_b);
        end
    endtask

    task automatic test_raster();
        int first_fs, second_fs;
        first_fs  = -1;
        second_fs = -1;
        rstn_a = 1'b1;
        en_a   = 1'b1;
        #1;
        n_a = 0;
        model(n_a, 2, en_a, 1'b0, exp_a, vis_a);
        for (int c = 0; c < 200; c++) begin
            if (c > 0) tick_a(1'b1);
            checks++;
            if (obs_a() !== exp_a) begin
                errors++;
                $display("FAIL raster c=%0d got %h want %h", c, obs_a(), exp_a);
            end
            if (bus_a.frame_start === 1'b1) begin
                if (first_fs < 0) first_fs = c;
                else if (second_fs < 0) second_fs = c;
            end
        end
        checks++;
        if (first_fs !== 1) begin
            errors++;
            $display("FAIL first_frame_start got %0d want 1", first_fs);
        end
        checks++;
        if (second_fs - first_fs !== 96) begin
            errors++;
            $display("FAIL frame_period got %0d want 96", second_fs - first_fs);
        end
    endtask

    task automatic test_sync();
        int hs_run, vs_run, hs_pulses, vs_pulses;
        bit hs_armed, vs_armed;
        logic prev_hs;
        hs_run = 0; vs_run = 0; hs_pulses = 0; vs_pulses = 0;
        hs_armed = 1'b0; vs_armed = 1'b0;
        prev_hs = bus_a.HS;
        for (int c = 0; c < 200; c++) begin
            tick_a(1'b1);
            checks++;
            if (obs_a() !== exp_a) begin
                errors++;
                $display("FAIL sync_model c=%0d got %h want %h", c, obs_a(), exp_a);
            end
            if (bus_a.HS === 1'b0 && prev_hs === 1'b1) begin
                checks++;
                if (bus_a.x !== 3'd6) begin
                    errors++;
                    $display("FAIL hs_fall_x got %0d want 6", bus_a.x);
                end
            end
            prev_hs = bus_a.HS;
            if (bus_a.HS === 1'b0) begin
                if (hs_armed) hs_run++;
            end else begin
                if (hs_run > 0) begin
                    checks++;
                    if (hs_run !== 4) begin
                        errors++;
                        $display("FAIL hs_width got %0d want 4", hs_run);
                    end
                    hs_pulses++;
                end
                hs_run = 0;
                hs_armed = 1'b1;
            end
            if (bus_a.VS === 1'b0) begin
                if (vs_armed) vs_run++;
            end else begin
                if (vs_run > 0) begin
                    checks++;
                    if (vs_run !== 16) begin
                        errors++;
                        $display("FAIL vs_width got %0d want 16", vs_run);
                    end
                    vs_pulses++;
                end
                vs_run = 0;
                vs_armed = 1'b1;
            end
        end
        checks++;
        if (hs_pulses < 11 || vs_pulses < 1) begin
            errors++;
            $display("FAIL sync_pulse_count got hs=%0d vs=%0d want hs>=11 vs>=1", hs_pulses, vs_pulses);
        end
    endtask

    task automatic test_blanking();
        int lit;
        lit = 0;
        rand_pix = 1'b0;
        fix_r = 4'hA;
        for (int c = 0; c < 96; c++) begin
            tick_a(1'b1);
            checks++;
            if ({bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B} !== exp_rgb_a()) begin
                errors++;
                $display("FAIL blank_rgb c=%0d got %h want %h", c,
                         {bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B}, exp_rgb_a());
            end
            if (bus_a.VGA_R !== 4'h0) lit++;
        end
        checks++;
        if (lit !== 24) begin
            errors++;
            $display("FAIL lit_pixels got %0d clk want 24 (12 pixels)", lit);
        end
        rand_pix = 1'b1;
    endtask

    task automatic test_enable();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            tick_a(1'b1);
            if (exp_a.x == 3'd3 && exp_a.y == 3'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL enable_seek got none want x=3 y=2");
        end
        en_a = 1'b0;
        #1;
        model(n_a, 2, en_a, 1'b0, exp_a, vis_a);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick_a(1'b0);
            checks++;
            if (obs_a() !== exp_a || bus_a.pix_ce !== 1'b0) begin
                errors++;
                $display("FAIL enable_off c=%0d got %h want %h", c, obs_a(), exp_a);
            end
            if (c > 0) begin
                checks++;
                if ({bus_a.x, bus_a.y, bus_a.HS, bus_a.VS, bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B}
                    !== {3'd0, 3'd0, 1'b1, 1'b1, 12'h000}) begin
                    errors++;
                    $display("FAIL enable_idle c=%0d got x=%0d y=%0d hs=%b vs=%b rgb=%h want 0 0 1 1 000",
                             c, bus_a.x, bus_a.y, bus_a.HS, bus_a.VS,
                             {bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B});
                end
            end
        end
        tick_a(1'b1);
        checks++;
        if (bus_a.frame_start !== 1'b0 || obs_a() !== exp_a) begin
            errors++;
            $display("FAIL reenable_first got fs=%b sig=%h want fs=0 sig=%h", bus_a.frame_start, obs_a(), exp_a);
        end
        tick_a(1'b1);
        checks++;
        if (bus_a.frame_start !== 1'b1 || bus_a.x !== 3'd0 || bus_a.y !== 3'd0) begin
            errors++;
            $display("FAIL reenable_fs got fs=%b x=%0d y=%0d want 1 0 0", bus_a.frame_start, bus_a.x, bus_a.y);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        sig_t idle_a;
        idle_a = {3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            tick_a(1'b1);
            if (exp_a.x == 3'd6 && exp_a.y == 3'd1) found = 1'b1;
        end
        checks++;
        if (!found || bus_a.HS !== 1'b0) begin
            errors++;
            $display("FAIL areset_setup got found=%b hs=%b want 1 0", found, bus_a.HS);
        end
        #1;
        rstn_a = 1'b0;
        #1;
        checks++;
        if (obs_a() !== idle_a || {bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B} !== 12'h000) begin
            errors++;
            $display("FAIL areset_immediate got %h rgb=%h want %h rgb=000", obs_a(),
                     {bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B}, idle_a);
        end
        @(negedge clk);
        rstn_a = 1'b1;
        en_a   = 1'b1;
        #1;
        n_a = 0;
        model(n_a, 2, en_a, 1'b0, exp_a, vis_a);
        for (int c = 0; c < 24; c++) begin
            if (c > 0) tick_a(1'b1);
            checks++;
            if (obs_a() !== exp_a || {bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B} !== exp_rgb_a()) begin
                errors++;
                $display("FAIL areset_restart c=%0d got %h want %h", c, obs_a(), exp_a);
            end
        end
    endtask

    task automatic test_random();
        bit en_v;
        for (int c = 0; c < 400; c++) begin
            en_v = ($urandom_range(0, 7) != 0);
            tick_a(en_v);
            checks++;
            if (obs_a() !== exp_a || {bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B} !== exp_rgb_a()) begin
                errors++;
                $display("FAIL random c=%0d got %h rgb=%h want %h rgb=%h", c, obs_a(),
                         {bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B}, exp_a, exp_rgb_a());
            end
        end
    endtask

    task automatic test_div1();
        int hs_run, pulses;
        bit armed;
        hs_run = 0;
        pulses = 0;
        armed  = 1'b0;
        @(negedge clk);
        rstn_b = 1'b1;
        en_b   = 1'b1;
        #1;
        n_b = 0;
        model(n_b, 1, en_b, 1'b1, exp_b, vis_b);
        for (int c = 0; c < 100; c++) begin
            if (c > 0) tick_b();
            checks++;
            if (obs_b() !== exp_b || bus_b.pix_ce !== 1'b1) begin
                errors++;
                $display("FAIL div1 c=%0d got %h want %h", c, obs_b(), exp_b);
            end
            if (bus_b.HS === 1'b1) begin
                if (armed) hs_run++;
            end else begin
                if (hs_run > 0) begin
                    checks++;
                    if (hs_run !== 2) begin
                        errors++;
                        $display("FAIL div1_hs_width got %0d want 2", hs_run);
                    end
                    pulses++;
                end
                hs_run = 0;
                armed  = 1'b1;
            end
        end
        checks++;
        if (pulses < 10) begin
            errors++;
            $display("FAIL div1_hs_pulses got %0d want >=10", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_sync();
        test_blanking();
        test_enable();
        test_async_reset();
        test_random();
        test_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
